// File: rtl/toy_bpu_l0btb_conf_pkg.sv
// Shared L0 BTB definitions: entry payload struct, BP0 width/confidence constants,
// and the fall-through (not-taken) next-fetch helpers.
package toy_pack;

    localparam int BP0_ADDR_W    = 32;
    localparam int BP0_TAG_W     = 12;
    localparam int BP0_OFFSET_W  = 4;
    localparam int BP0_ALIGN_W   = 5;
    localparam int BP0_CONF_W    = 2;
    localparam int BP0_CONF_INIT = 2;

    typedef struct packed {
        logic [BP0_TAG_W-1:0]    tag;
        logic [BP0_ADDR_W-1:0]   tgt_pc;
        logic [BP0_OFFSET_W-1:0] offset;
        logic                    is_cext;
        logic                    carry;
        logic [BP0_CONF_W-1:0]   conf;
    } l0btb_conf_entry_pkg;

    function automatic logic [BP0_TAG_W-1:0] bp0_tag(input logic [BP0_ADDR_W-1:0] pc);
        return pc[BP0_TAG_W:1];
    endfunction

    function automatic logic [BP0_ADDR_W-1:0] bp0_ft_tgt(input logic [BP0_ADDR_W-1:0] pc);
        return {pc[BP0_ADDR_W-1:BP0_ALIGN_W], {BP0_ALIGN_W{1'b0}}} + BP0_ADDR_W'(1 << BP0_ALIGN_W);
    endfunction

    // Last slot of the block counted back from the lookup position.
    function automatic logic [BP0_OFFSET_W-1:0] bp0_ft_offset(input logic [BP0_ADDR_W-1:0] pc);
        return {BP0_OFFSET_W{1'b1}} - BP0_OFFSET_W'(pc[BP0_ALIGN_W-1:2]);
    endfunction

endpackage

// File: rtl/toy_bpu_l0btb_conf_if.sv
// Lookup/prediction and training-update bundle between PC-gen/FE controller and the L0 BTB.
interface toy_bpu_l0btb_conf_if;
    import toy_pack::*;

    logic                    pcgen_vld;
    logic [BP0_ADDR_W-1:0]   pcgen_pc;
    logic                    pred_vld;
    logic                    pred_taken;
    logic [BP0_ADDR_W-1:0]   pred_tgt_pc;
    logic [BP0_OFFSET_W-1:0] pred_offset;
    logic                    pred_is_cext;
    logic                    pred_carry;
    logic                    upd_vld;
    logic [BP0_ADDR_W-1:0]   upd_pc;
    logic                    upd_taken;
    logic [BP0_ADDR_W-1:0]   upd_tgt_pc;
    logic [BP0_OFFSET_W-1:0] upd_offset;
    logic                    upd_is_cext;
    logic                    upd_carry;

    modport master (
        output pcgen_vld, pcgen_pc,
        output upd_vld, upd_pc, upd_taken, upd_tgt_pc, upd_offset, upd_is_cext, upd_carry,
        input  pred_vld, pred_taken, pred_tgt_pc, pred_offset, pred_is_cext, pred_carry
    );

    modport slave (
        input  pcgen_vld, pcgen_pc,
        input  upd_vld, upd_pc, upd_taken, upd_tgt_pc, upd_offset, upd_is_cext, upd_carry,
        output pred_vld, pred_taken, pred_tgt_pc, pred_offset, pred_is_cext, pred_carry
    );

endinterface

// File: rtl/toy_bpu_l0btb_conf_entry.sv
// One L0 BTB entry: valid bit, payload and saturating confidence counter.
// write loads the payload (and conf on allocation); inc/dec move the counter.
module toy_bpu_l0btb_conf_entry
    import toy_pack::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write,
    input  logic                inc,
    input  logic                dec,
    input  logic                flush,
    input  l0btb_conf_entry_pkg wdata,
    output logic                valid,
    output l0btb_conf_entry_pkg payload
);

    logic                valid_q, valid_d;
    l0btb_conf_entry_pkg ent_q, ent_d;

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        if (flush) begin
            valid_d = 1'b0;
        end else begin
            if (write) begin
                ent_d   = wdata;
                valid_d = 1'b1;
            end
            // A taken retrain keeps the trained counter instead of wdata.conf.
            if (inc) begin
                ent_d.conf = (ent_q.conf == '1) ? ent_q.conf : ent_q.conf + BP0_CONF_W'(1);
            end
            if (dec) begin
                ent_d.conf = (ent_q.conf == '0) ? ent_q.conf : ent_q.conf - BP0_CONF_W'(1);
                if (ent_q.conf <= BP0_CONF_W'(1)) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

    assign valid   = valid_q;
    assign payload = ent_q;

endmodule

// File: rtl/toy_bpu_l0btb_conf.sv
// Fully associative zero-bubble BTB with per-entry confidence hysteresis and a one-cycle
// update buffer that bypasses to lookup. Define TOY_BPU_L0BTB_PLRU_EN for tree-PLRU replacement.
module toy_bpu_l0btb_conf
    import toy_pack::*;
#(
    parameter int ENTRY_NUM    = 8,
    parameter int ADDR_WIDTH   = BP0_ADDR_W,
    parameter int TAG_WIDTH    = BP0_TAG_W,
    parameter int OFFSET_WIDTH = BP0_OFFSET_W,
    parameter int ALIGN_WIDTH  = BP0_ALIGN_W,
    parameter int CONF_WIDTH   = BP0_CONF_W,
    parameter int CONF_INIT    = BP0_CONF_INIT,
    localparam int IDX_W       = $clog2(ENTRY_NUM),
    localparam int OCC_W       = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    toy_bpu_l0btb_conf_if.slave      bif,
    input  logic                     flush,
    output logic [OCC_W-1:0]         occupancy
);

    // Payload widths come from toy_pack; the parameters must agree with it.
    if (ADDR_WIDTH != BP0_ADDR_W || TAG_WIDTH != BP0_TAG_W || OFFSET_WIDTH != BP0_OFFSET_W ||
        ALIGN_WIDTH != BP0_ALIGN_W || CONF_WIDTH != BP0_CONF_W || CONF_INIT != BP0_CONF_INIT ||
        ENTRY_NUM < 2 || (ENTRY_NUM & (ENTRY_NUM - 1)) != 0) begin : g_cfg_err
        $error("toy_bpu_l0btb_conf: parameters must match toy_pack, ENTRY_NUM power of two >= 2");
    end

    logic [BP0_TAG_W-1:0]  lk_tag;
    logic [ENTRY_NUM-1:0]  ent_vld, lk_hit, up_hit, ent_wr, ent_inc, ent_dec;
    l0btb_conf_entry_pkg   ent_pay [ENTRY_NUM];
    logic                  buf_hit, lk_any, up_any, inv_any;
    logic                  apply, alloc, alloc_new, invalidate;
    logic [IDX_W-1:0]      lk_idx, up_idx, inv_idx, repl_idx, victim_idx;

    logic                  buf_vld_q, buf_vld_d, buf_taken_q, buf_taken_d;
    l0btb_conf_entry_pkg   buf_ent_q, buf_ent_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  unused_upd_pc;

    assign unused_upd_pc = ^{bif.upd_pc[BP0_ADDR_W-1:BP0_TAG_W+1], bif.upd_pc[0]};

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
        toy_bpu_l0btb_conf_entry u_ent (
            .clk     (clk),
            .rst_n   (rst_n),
            .write   (ent_wr[g]),
            .inc     (ent_inc[g]),
            .dec     (ent_dec[g]),
            .flush   (flush),
            .wdata   (buf_ent_q),
            .valid   (ent_vld[g]),
            .payload (ent_pay[g])
        );
    end

    always_comb begin
        buf_vld_d   = bif.upd_vld && !flush;
        buf_taken_d = buf_taken_q;
        buf_ent_d   = buf_ent_q;
        if (bif.upd_vld) begin
            buf_taken_d       = bif.upd_taken;
            buf_ent_d.tag     = bp0_tag(bif.upd_pc);
            buf_ent_d.tgt_pc  = bif.upd_tgt_pc;
            buf_ent_d.offset  = bif.upd_offset;
            buf_ent_d.is_cext = bif.upd_is_cext;
            buf_ent_d.carry   = bif.upd_carry;
            buf_ent_d.conf    = BP0_CONF_W'(BP0_CONF_INIT);
        end
    end

    // Reverse scans leave the lowest matching index in each *_idx.
    always_comb begin
        lk_tag  = bp0_tag(bif.pcgen_pc);
        lk_hit  = '0;
        up_hit  = '0;
        lk_idx  = '0;
        up_idx  = '0;
        inv_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            lk_hit[i] = ent_vld[i] && (ent_pay[i].tag == lk_tag) && ent_pay[i].conf[BP0_CONF_W-1];
            up_hit[i] = ent_vld[i] && (ent_pay[i].tag == buf_ent_q.tag);
            if (lk_hit[i])   lk_idx  = IDX_W'(i);
            if (up_hit[i])   up_idx  = IDX_W'(i);
            if (!ent_vld[i]) inv_idx = IDX_W'(i);
        end
        lk_any  = |lk_hit;
        up_any  = |up_hit;
        inv_any = !(&ent_vld);
        buf_hit = buf_vld_q && buf_taken_q && (buf_ent_q.tag == lk_tag);
    end

    always_comb begin
        bif.pred_vld     = bif.pcgen_vld;
        bif.pred_taken   = buf_hit || lk_any;
        bif.pred_tgt_pc  = bp0_ft_tgt(bif.pcgen_pc);
        bif.pred_offset  = bp0_ft_offset(bif.pcgen_pc);
        bif.pred_is_cext = 1'b0;
        bif.pred_carry   = 1'b0;
        if (buf_hit) begin
            bif.pred_tgt_pc  = buf_ent_q.tgt_pc;
            bif.pred_offset  = buf_ent_q.offset;
            bif.pred_is_cext = buf_ent_q.is_cext;
            bif.pred_carry   = buf_ent_q.carry;
        end else if (lk_any) begin
            bif.pred_tgt_pc  = ent_pay[lk_idx].tgt_pc;
            bif.pred_offset  = ent_pay[lk_idx].offset;
            bif.pred_is_cext = ent_pay[lk_idx].is_cext;
            bif.pred_carry   = ent_pay[lk_idx].carry;
        end
    end

    always_comb begin
        apply      = buf_vld_q && !flush;
        alloc      = apply && buf_taken_q && !up_any;
        alloc_new  = alloc && inv_any;
        invalidate = apply && !buf_taken_q && up_any && (ent_pay[up_idx].conf <= BP0_CONF_W'(1));
        victim_idx = inv_any ? inv_idx : repl_idx;
        ent_wr     = '0;
        ent_inc    = '0;
        ent_dec    = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            ent_wr[i]  = apply && buf_taken_q &&
                         (up_any ? (up_idx == IDX_W'(i)) : (victim_idx == IDX_W'(i)));
            ent_inc[i] = apply && buf_taken_q && up_any && (up_idx == IDX_W'(i));
            ent_dec[i] = apply && !buf_taken_q && up_any && (up_idx == IDX_W'(i));
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush)           occ_d = '0;
        else if (alloc_new)  occ_d = occ_q + OCC_W'(1);
        else if (invalidate) occ_d = occ_q - OCC_W'(1);
    end

`ifdef TOY_BPU_L0BTB_PLRU_EN
    // Tree node n has children 2n+1 (bit=0 side) and 2n+2; each bit points toward the victim.
    logic [ENTRY_NUM-2:0] plru_q, plru_d;
    logic                 wr_any;
    logic [IDX_W-1:0]     wr_idx;

    function automatic logic [IDX_W-1:0] plru_victim(input logic [ENTRY_NUM-2:0] t);
        logic [IDX_W-1:0] node, idx;
        logic             b;
        node = '0;
        idx  = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b    = t[node];
            idx  = (idx << 1) | IDX_W'(b);
            node = (node << 1) + IDX_W'(1) + IDX_W'(b);
        end
        return idx;
    endfunction

    function automatic logic [ENTRY_NUM-2:0] plru_touch(input logic [ENTRY_NUM-2:0] t,
                                                        input logic [IDX_W-1:0]     leaf);
        logic [ENTRY_NUM-2:0] r;
        logic [IDX_W-1:0]     node;
        logic                 b;
        r    = t;
        node = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b       = leaf[IDX_W-1-l];
            r[node] = ~b;
            node    = (node << 1) + IDX_W'(1) + IDX_W'(b);
        end
        return r;
    endfunction

    always_comb begin
        repl_idx = plru_victim(plru_q);
        wr_any   = apply && (buf_taken_q || up_any);
        wr_idx   = up_any ? up_idx : victim_idx;
        plru_d   = plru_q;
        if (bif.pcgen_vld && lk_any) plru_d = plru_touch(plru_d, lk_idx);
        if (wr_any)                  plru_d = plru_touch(plru_d, wr_idx);
        if (flush)                   plru_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) plru_q <= '0;
        else        plru_q <= plru_d;
    end
`else
    // An all-zero pointer (after reset or flush) stands for entry 0.
    logic [ENTRY_NUM-1:0] rr_q, rr_d, rr_oh;

    always_comb begin
        rr_oh    = (rr_q == '0) ? ENTRY_NUM'(1) : rr_q;
        repl_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (rr_oh[i]) repl_idx = IDX_W'(i);
        end
        rr_d = rr_q;
        if (flush)                 rr_d = '0;
        else if (alloc && !inv_any) rr_d = {rr_oh[ENTRY_NUM-2:0], rr_oh[ENTRY_NUM-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q   <= 1'b0;
            buf_taken_q <= 1'b0;
            buf_ent_q   <= '0;
            occ_q       <= '0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_taken_q <= buf_taken_d;
            buf_ent_q   <= buf_ent_d;
            occ_q       <= occ_d;
        end
    end

    assign occupancy = occ_q;

    a_lk_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lk_hit));
    a_up_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(up_hit));

endmodule

// File: tb/tb_toy_bpu_l0btb_conf.sv
// Scoreboard bench for toy_bpu_l0btb_conf: expected predictions are queued as each lookup
// is driven and popped/compared once the combinational outputs have settled.
module tb_toy_bpu_l0btb_conf;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] occupancy;
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        string       tag;
        logic        vld;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  off;
        logic        cext;
        logic        carry;
    } pred_exp_t;

    pred_exp_t exp_q[$];

    toy_bpu_l0btb_conf_if bif ();

    toy_bpu_l0btb_conf #(.ENTRY_NUM(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bif       (bif.slave),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ft_tgt(input logic [31:0] pc);
        return (pc & 32'hFFFF_FFE0) + 32'd32;
    endfunction

    function automatic logic [3:0] ft_off(input logic [31:0] pc);
        return 4'd15 - {1'b0, pc[4:2]};
    endfunction

    function automatic logic [31:0] f_pc(input int i);
        return 32'h100 + 32'(i) * 32'h40;
    endfunction

    function automatic logic [31:0] f_tgt(input int i);
        return 32'h8000 + 32'(i) * 32'h100;
    endfunction

    task automatic nxt();
        @(negedge clk);
        bif.upd_vld   = 1'b0;
        bif.pcgen_vld = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [3:0] off, input logic cext, input logic carry);
        bif.upd_vld     = 1'b1;
        bif.upd_pc      = pc;
        bif.upd_taken   = tk;
        bif.upd_tgt_pc  = tgt;
        bif.upd_offset  = off;
        bif.upd_is_cext = cext;
        bif.upd_carry   = carry;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic vld, input logic tk,
                        input logic [31:0] tgt, input logic [3:0] off, input logic cext,
                        input logic carry);
        pred_exp_t e;
        pred_exp_t o;
        e.tag = tag; e.vld = vld; e.taken = tk; e.tgt = tgt;
        e.off = off; e.cext = cext; e.carry = carry;
        exp_q.push_back(e);
        bif.pcgen_vld = vld;
        bif.pcgen_pc  = pc;
        #1;
        o = exp_q.pop_front();
        check_val({o.tag, ".vld"},   64'(bif.pred_vld),     64'(o.vld));
        check_val({o.tag, ".taken"}, 64'(bif.pred_taken),   64'(o.taken));
        check_val({o.tag, ".tgt"},   64'(bif.pred_tgt_pc),  64'(o.tgt));
        check_val({o.tag, ".off"},   64'(bif.pred_offset),  64'(o.off));
        check_val({o.tag, ".cext"},  64'(bif.pred_is_cext), 64'(o.cext));
        check_val({o.tag, ".carry"}, 64'(bif.pred_carry),   64'(o.carry));
    endtask

    task automatic look_miss(input string tag, input logic [31:0] pc);
        look(tag, pc, 1'b1, 1'b0, ft_tgt(pc), ft_off(pc), 1'b0, 1'b0);
    endtask

    task automatic look_fill(input string tag, input int i);
        logic [31:0] v;
        v = 32'(i);
        look(tag, f_pc(i), 1'b1, 1'b1, f_tgt(i), v[3:0], v[0], v[1]);
    endtask

    task automatic upd_fill(input int i);
        logic [31:0] v;
        v = 32'(i);
        upd(f_pc(i), 1'b1, f_tgt(i), v[3:0], v[0], v[1]);
    endtask

    initial begin
        bif.pcgen_vld = 1'b0; bif.pcgen_pc = '0;
        bif.upd_vld = 1'b0; bif.upd_pc = '0; bif.upd_taken = 1'b0; bif.upd_tgt_pc = '0;
        bif.upd_offset = '0; bif.upd_is_cext = 1'b0; bif.upd_carry = 1'b0;

        // reset state
        #1;
        look_miss("rst", 32'h1000);
        check_val("rst.occ", 64'(occupancy), 64'd0);
        nxt(); rst_n = 1'b1;

        // allocate, bypass, then array hit
        nxt(); upd(32'h1000, 1'b1, 32'h2000, 4'd3, 1'b1, 1'b0);
        nxt(); look("byp", 32'h1000, 1'b1, 1'b1, 32'h2000, 4'd3, 1'b1, 1'b0);
        nxt(); look("arr", 32'h1000, 1'b1, 1'b1, 32'h2000, 4'd3, 1'b1, 1'b0);
        check_val("arr.occ", 64'(occupancy), 64'd1);

        // two not-taken updates: conf 2 -> 1 -> 0
        nxt(); upd(32'h1000, 1'b0, 32'h2000, 4'd3, 1'b1, 1'b0);
        nxt(); look("nt_pend", 32'h1000, 1'b1, 1'b1, 32'h2000, 4'd3, 1'b1, 1'b0);
        nxt(); upd(32'h1000, 1'b0, 32'h2000, 4'd3, 1'b1, 1'b0);
        look_miss("conf1", 32'h1000);
        look_miss("conf1_off", 32'h100C);
        check_val("conf1.occ", 64'(occupancy), 64'd1);
        nxt();
        nxt(); look_miss("inv", 32'h1000);
        check_val("inv.occ", 64'(occupancy), 64'd0);

        // saturation at 3, then two not-taken keep it valid at conf 1
        nxt(); upd(32'h1000, 1'b1, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); upd(32'h1000, 1'b1, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); upd(32'h1000, 1'b1, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); upd(32'h1000, 1'b0, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); upd(32'h1000, 1'b0, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); look("sat2", 32'h1000, 1'b1, 1'b1, 32'h2100, 4'd5, 1'b0, 1'b1);
        nxt(); look_miss("sat1", 32'h1000);
        check_val("sat1.occ", 64'(occupancy), 64'd1);
        upd(32'h1000, 1'b1, 32'h2200, 4'd6, 1'b0, 1'b1);
        nxt(); look("retrain_byp", 32'h1000, 1'b1, 1'b1, 32'h2200, 4'd6, 1'b0, 1'b1);
        nxt(); look("retrain_arr", 32'h1000, 1'b1, 1'b1, 32'h2200, 4'd6, 1'b0, 1'b1);
        check_val("retrain.occ", 64'(occupancy), 64'd1);

        // flush with a concurrent update: lookup still sees pre-flush table
        nxt(); flush = 1'b1; upd(32'h3000, 1'b1, 32'h3300, 4'd1, 1'b0, 1'b0);
        look("pre_flush", 32'h1000, 1'b1, 1'b1, 32'h2200, 4'd6, 1'b0, 1'b1);
        nxt(); look_miss("flush_old", 32'h1000);
        look_miss("flush_drop", 32'h3000);
        check_val("flush.occ", 64'(occupancy), 64'd0);
        nxt(); look_miss("flush_drop2", 32'h3000);
        check_val("flush2.occ", 64'(occupancy), 64'd0);

        // fill all eight entries
        for (int i = 0; i < 8; i++) begin
            nxt(); upd_fill(i);
        end
        nxt();
        nxt(); check_val("fill.occ", 64'(occupancy), 64'd8);
        for (int i = 0; i < 8; i++) begin
            look_fill($sformatf("fill%0d", i), i);
            nxt();
        end
        look("novld", f_pc(1), 1'b0, 1'b1, f_tgt(1), 4'd1, 1'b1, 1'b0);

`ifdef TOY_BPU_L0BTB_PLRU_EN
        for (int k = 0; k < 6; k++) begin
            nxt(); look_fill($sformatf("plru_hit%0d", k), 0);
        end
        nxt(); upd_fill(8);
        nxt();
        nxt(); look_fill("plru_keep0", 0);
        nxt(); look_fill("plru_new", 8);
        check_val("plru.occ", 64'(occupancy), 64'd8);
`else
        for (int j = 0; j < 4; j++) begin
            nxt(); upd_fill(8 + j);
            nxt();
            nxt(); look_miss($sformatf("rr_evict%0d", j), f_pc(j));
            nxt(); look_fill($sformatf("rr_new%0d", j), 8 + j);
            nxt(); look_fill($sformatf("rr_keep%0d", j), j + 1);
            check_val($sformatf("rr%0d.occ", j), 64'(occupancy), 64'd8);
        end
`endif

        // asynchronous reset with the update buffer holding a taken update
        nxt(); upd(32'h5000, 1'b1, 32'h6000, 4'd7, 1'b0, 1'b0);
        nxt(); rst_n = 1'b0;
        look_miss("rst_byp", 32'h5000);
        look_miss("rst_arr", f_pc(8));
        check_val("rst_mid.occ", 64'(occupancy), 64'd0);
        nxt(); rst_n = 1'b1;
        nxt(); look_miss("post_rst", 32'h5000);
        look_miss("post_rst_arr", f_pc(8));
        check_val("post_rst.occ", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toy_bpu_l0btb_conf.md
Name: toy_bpu_l0btb_conf

Overview:
Parametrised zero-bubble (L0) branch target buffer with per-entry saturating confidence counters. It replaces single-shot allocate/invalidate with hysteresis.
- Fully associative, ENTRY_NUM entries.
- Predicts combinationally in the PC-gen cycle and feeds BP decode and the FE controller.
- Training updates arrive from the FE controller. They are held one cycle in an update buffer, with bypass to lookup, before being written to the array.

Parameters:
ENTRY_NUM, 8, number of entries; power of two, >=2
ADDR_WIDTH, 32, PC width
TAG_WIDTH, 12, tag = pc[TAG_WIDTH:1]
OFFSET_WIDTH, 4, branch slot offset inside fetch block
ALIGN_WIDTH, 5, log2 of fetch block bytes
CONF_WIDTH, 2, confidence counter width
CONF_INIT, 2, counter value on allocation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pcgen_vld  in  1  lookup request
pcgen_pc  in  ADDR_WIDTH  lookup PC
pred_vld  out  1  equals pcgen_vld
pred_taken  out  1  predicted taken
pred_tgt_pc  out  ADDR_WIDTH  next fetch PC
pred_offset  out  OFFSET_WIDTH  last valid slot of this fetch
pred_is_cext  out  1  predicted branch is compressed
pred_carry  out  1  branch straddles block
upd_vld  in  1  training update
upd_pc  in  ADDR_WIDTH  branch fetch PC
upd_taken  in  1  resolved direction
upd_tgt_pc  in  ADDR_WIDTH  resolved target
upd_offset  in  OFFSET_WIDTH  branch offset
upd_is_cext  in  1  compressed flag
upd_carry  in  1  carry flag
flush  in  1  invalidate whole table
occupancy  out  log2(ENTRY_NUM)+1  number of valid entries

Behaviour:
Clock, reset and outputs:
- One clock. Reset is asynchronous and active-low on rst_n.
- Reset state: all valid bits, counters, update buffer and replacement state are 0, so occupancy=0.
- All prediction outputs are combinational. With pcgen_vld=0 they still reflect pcgen_pc, and pred_vld=0.

Lookup hit rules:
- Entry hit = valid & tag match & counter MSB=1.
- Buffer hit = buffer valid & buf.taken & buffer tag == lookup tag. A buffer hit has priority over array hits.
- If several array entries hit, the lowest index wins. This is illegal by construction and is asserted.

Prediction outputs:
- pred_taken = any hit.
- Taken: outputs come from the hitting source.
- Not taken:
  - pred_tgt_pc = {pcgen_pc[ADDR_WIDTH-1:ALIGN_WIDTH], 0} + 2^ALIGN_WIDTH.
  - pred_offset = all-ones - pcgen_pc[ALIGN_WIDTH-1:2].
  - pred_is_cext = 0 and pred_carry = 0.

Update buffer:
- upd_vld registers the update into a one-entry buffer. It is applied to the array on the following cycle.
- Back-to-back updates are accepted every cycle, so the buffer never stalls.

Array apply (buffer valid), tag-hit case (valid & tag match, MSB not required):
- taken: counter saturating +1; payload overwritten.
- not taken: counter saturating -1. If the result is 0, the valid bit clears.

Array apply, tag-miss case:
- taken: allocate a victim with counter=CONF_INIT, valid=1.
- not taken: no change.

Victim selection:
- The lowest-index invalid entry is used first.
- Otherwise the replacement state picks the victim.
- Default replacement is a round-robin one-hot pointer. It rotates only when it supplies a victim, and wraps from ENTRY_NUM-1 to 0.

Flush:
- Flush clears all valid bits, the buffer valid bit and the replacement state on the next edge.
- flush together with upd_vld drops that update.
- A lookup in the flush cycle still uses the pre-flush contents.

Occupancy:
- occupancy is a register updated as +1 on allocation to an invalid entry and -1 on invalidation.
- It is 0 after flush.

Optional Feature:
TOY_BPU_L0BTB_PLRU_EN
- Defined: the replacement state is a tree pseudo-LRU of ENTRY_NUM-1 bits. Every array hit and every array write touches its entry, and the victim is the PLRU leaf.
  - If the lookup-hit entry and the update-written entry differ in one cycle, the update touch is applied last.
- Undefined: round-robin pointer as above, with no touch on hit.

Decomposition:
- Shared package (toy_pack) holds:
  - the l0btb_conf_entry_pkg struct: tag, tgt_pc, offset, is_cext, carry, conf;
  - the BP0_* width and CONF constants;
  - the fall-through target/offset helper function.
- Sub-module toy_bpu_l0btb_conf_entry: one entry. It holds the valid bit, the payload and the saturating counter. Inputs are write, inc, dec and flush; outputs are valid and payload.
- The replacement logic stays in the top module.

Test Plan:
- Update pc=0x1000, taken, tgt=0x2000, offset=3. The next cycle's lookup of 0x1000 returns bypass taken, tgt 0x2000, offset 3. The cycle after returns the array hit, counter=2, occupancy=1.
- Same entry, two not-taken updates: the first makes conf=1, and a lookup of 0x1000 is now not-taken with tgt 0x1020 and offset 15-0=15. The second makes conf=0, the entry is invalid and occupancy=0.
- Three taken updates to 0x1000: the counter saturates at 3. Two not-taken updates leave conf=1 and the entry valid; the entry still hits on tag for training.
- Fill 8 distinct PCs, then 4 more allocations. Round-robin victims are entries 0,1,2,3 in order. Under TOY_BPU_L0BTB_PLRU_EN, after repeatedly hitting entry 0, the first victim is not entry 0.
- flush asserted with a valid upd_vld: the next cycle every lookup is not-taken and occupancy=0. The dropped update never appears.
- Assert rst_n low mid-stream with the buffer valid: outputs immediately read not-taken fall-through and occupancy=0. After release the first lookup misses.
